// File: rtl/bcd_countdown_timer.sv
// BCD M:SS countdown register: keypad digits shift in while idle, one-second
// decrements while enabled, with a zero flag and a registered done pulse.
module bcd_countdown_timer #(
    parameter logic [3:0] MAX_DIGIT     = 4'd9,
    parameter logic [3:0] SEC_TENS_WRAP = 4'd5
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       zero,
    output logic       done,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SET   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] mins_q, mins_d;
    logic       done_q, done_d;
    logic       loadn_q;

    logic count_zero;
    logic at_one;
    logic key_valid;
    logic dec;

    assign count_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign at_one     = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
    // A key is one falling edge of loadn; holding it low does not repeat.
    assign key_valid  = loadn_q && !loadn && !en && (data <= MAX_DIGIT);
    assign dec        = pgt_1Hz && en && !count_zero;

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q <= ST_EMPTY;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            mins_q  <= 4'd0;
            done_q  <= 1'b0;
            loadn_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            mins_q  <= mins_d;
            done_q  <= done_d;
            loadn_q <= loadn;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (key_valid) state_d = ST_SET;
            ST_SET: begin
                if (key_valid)                 state_d = ST_SET;
                else if (en && !count_zero)    state_d = ST_RUN;
                else if (en)                   state_d = ST_EMPTY;
            end
            ST_RUN: begin
                if (!en)                       state_d = ST_SET;
                else if (dec && at_one)        state_d = ST_DONE;
            end
            ST_DONE: begin
                if (key_valid)                 state_d = ST_SET;
                else if (!en)                  state_d = ST_EMPTY;
            end
            default:                           state_d = ST_EMPTY;
        endcase
    end

    // Tick and key are mutually exclusive (key needs en=0, tick needs en=1).
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        mins_d = mins_q;
        done_d = 1'b0;
        if (dec) begin
            done_d = at_one;
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                if (tens_q != 4'd0) begin
                    tens_d = tens_q - 4'd1;
                end else begin
                    tens_d = SEC_TENS_WRAP;
                    mins_d = mins_q - 4'd1;
                end
            end
        end else if (key_valid) begin
            mins_d = tens_q;
            tens_d = ones_q;
            ones_d = data;
        end
    end

    always_comb begin
        sec_ones    = ones_q;
        sec_tens    = tens_q;
        mins        = mins_q;
        zero        = count_zero;
        done        = done_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: entry, countdown, terminal count,
// guards and asynchronous clear, checked with immediate assertions.
module tb_bcd_countdown_timer;

    logic       clock;
    logic       clearn;
    logic [3:0] data;
    logic       loadn;
    logic       pgt_1Hz;
    logic       en;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       zero;
    logic       done;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_SET   = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    bcd_countdown_timer dut (
        .clock       (clock),
        .clearn      (clearn),
        .data        (data),
        .loadn       (loadn),
        .pgt_1Hz     (pgt_1Hz),
        .en          (en),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .mins        (mins),
        .zero        (zero),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input logic [11:0] exp);
        check(tag, {20'd0, mins, sec_tens, sec_ones}, {20'd0, exp});
    endtask

    task automatic press_key(input logic [3:0] d, input int hold);
        data  = d;
        loadn = 1'b0;
        step(hold);
        loadn = 1'b1;
        step();
    endtask

    task automatic tick();
        pgt_1Hz = 1'b1;
        step();
        pgt_1Hz = 1'b0;
    endtask

    task automatic do_reset();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        step();
    endtask

    initial begin
        clearn  = 1'b0;
        data    = 4'd0;
        loadn   = 1'b1;
        pgt_1Hz = 1'b0;
        en      = 1'b0;
        step(2);
        check_count("reset_digits", 12'h000);
        check("reset_zero", {31'd0, zero}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, {30'd0, S_EMPTY});
        clearn = 1'b1;
        step();

        // Entry: each key held low three cycles shifts exactly once.
        press_key(4'd1, 3);
        check_count("entry_1", 12'h001);
        press_key(4'd3, 3);
        check_count("entry_13", 12'h013);
        press_key(4'd0, 3);
        check_count("entry_130", 12'h130);
        press_key(4'd7, 3);
        check_count("entry_307", 12'h307);
        check("entry_state", {30'd0, dbg_state}, {30'd0, S_SET});
        check("entry_zero", {31'd0, zero}, 32'd0);

        // Asynchronous clear mid-cycle, observed before the next edge.
        #2;
        clearn = 1'b0;
        #1;
        check_count("async_clr_digits", 12'h000);
        check("async_clr_zero", {31'd0, zero}, 32'd1);
        check("async_clr_done", {31'd0, done}, 32'd0);
        check("async_clr_state", {30'd0, dbg_state}, {30'd0, S_EMPTY});
        step();
        clearn = 1'b1;
        step();

        // Countdown from 1:00 with full borrow chain.
        press_key(4'd1, 1);
        press_key(4'd0, 1);
        press_key(4'd0, 1);
        check_count("load_100", 12'h100);
        en = 1'b1;
        step();
        check("run_state", {30'd0, dbg_state}, {30'd0, S_RUN});
        tick();
        check_count("cd_059", 12'h059);
        step(2);
        check_count("cd_hold_no_tick", 12'h059);
        tick();
        check_count("cd_058", 12'h058);
        tick();
        check_count("cd_057", 12'h057);
        check("cd_no_done", {31'd0, done}, 32'd0);

        // Terminal count from 0:02.
        en = 1'b0;
        do_reset();
        press_key(4'd2, 1);
        check_count("load_002", 12'h002);
        en = 1'b1;
        step();
        tick();
        check_count("term_001", 12'h001);
        check("term_done_early", {31'd0, done}, 32'd0);
        tick();
        check_count("term_000", 12'h000);
        check("term_done_pulse", {31'd0, done}, 32'd1);
        check("term_zero", {31'd0, zero}, 32'd1);
        check("term_state", {30'd0, dbg_state}, {30'd0, S_DONE});
        step();
        check("term_done_one_cycle", {31'd0, done}, 32'd0);
        tick();
        check_count("term_extra_tick", 12'h000);
        check("term_no_second_done", {31'd0, done}, 32'd0);
        tick();
        check_count("term_extra_tick2", 12'h000);
        check("term_zero_held", {31'd0, zero}, 32'd1);
        en = 1'b0;
        step();
        check("done_to_empty", {30'd0, dbg_state}, {30'd0, S_EMPTY});

        // Guards: simultaneous key and tick, illegal code, paused ticks.
        press_key(4'd1, 1);
        press_key(4'd9, 1);
        press_key(4'd5, 1);
        check_count("load_195", 12'h195);
        en = 1'b1;
        step();
        data    = 4'd5;
        loadn   = 1'b0;
        pgt_1Hz = 1'b1;
        step();
        pgt_1Hz = 1'b0;
        loadn   = 1'b1;
        check_count("key_and_tick", 12'h194);
        step();
        check_count("key_dropped", 12'h194);
        en = 1'b0;
        step();
        check("pause_state", {30'd0, dbg_state}, {30'd0, S_SET});
        press_key(4'hC, 1);
        check_count("illegal_code", 12'h194);
        tick();
        step();
        tick();
        check_count("pause_hold", 12'h194);
        en = 1'b1;
        step();
        check_count("resume_no_memory", 12'h194);
        tick();
        check_count("resume_tick", 12'h193);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
